// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle ARM datapath: instruction sequencer,
// ALU decoder, NZCV flag register, condition check and write-enable gating.
module multicycle_controller (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t     state;
    state_t     next;
    logic       irw;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic [1:0] aluctl;
    logic       nowrite;
    logic       sflag;
    logic [1:0] flagw;
    logic       condex;
    logic       condexreg;
    logic       pcs;
    logic       dp_nowrite;
    logic       n;
    logic       z;
    logic       c;
    logic       v;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= FETCH;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = FETCH;
        unique case (state)
            FETCH:  next = DECODE;
            DECODE: begin
                unique case (Op)
                    2'b00:   next = Funct[5] ? EXECI : EXECR;
                    2'b01:   next = MEMADR;
                    2'b10:   next = BRANCH;
                    default: next = FETCH;
                endcase
            end
            MEMADR: next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next = MEMWB;
            EXECR:  next = ALUWB;
            EXECI:  next = ALUWB;
            default: next = FETCH;
        endcase
    end

    always_comb begin
        irw       = 1'b0;
        nextpc    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        aluop     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        unique case (state)
            FETCH: begin
                irw       = 1'b1;
                nextpc    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECR: aluop = 1'b1;
            EXECI: begin
                aluop   = 1'b1;
                ALUSrcB = 2'b01;
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: begin
                irw = 1'b0;
            end
        endcase
    end

    always_comb begin
        aluctl  = ALU_ADD;
        nowrite = 1'b0;
        sflag   = Funct[0];
        unique case (Funct[4:1])
            4'b0100: aluctl = ALU_ADD;
            4'b0010: aluctl = ALU_SUB;
            4'b0000: aluctl = ALU_AND;
            4'b1100: aluctl = ALU_ORR;
            4'b1010: begin
                aluctl  = ALU_SUB;
                sflag   = 1'b1;
                nowrite = 1'b1;
            end
            default: begin
                aluctl  = ALU_ADD;
                nowrite = 1'b1;
            end
        endcase
    end

    // NoWrite comes from the held instruction so it still blocks ALUWB.
    assign dp_nowrite = (Op == 2'b00) & nowrite;
    assign ALUControl = aluop ? aluctl : ALU_ADD;
    assign flagw[1]   = aluop & sflag;
    assign flagw[0]   = aluop & sflag & ~aluctl[1];

    assign {n, z, c, v} = Flags;

    always_comb begin
        condex = 1'b0;
        unique case (Cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            condexreg <= 1'b0;
        end else if (next == FETCH) begin
            condexreg <= 1'b0;
        end else if (state == DECODE) begin
            condexreg <= condex;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            Flags <= 4'b0000;
        end else begin
            if (flagw[1] & condexreg) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (flagw[0] & condexreg) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign pcs = branch | (regw & (Rd == 4'hF));

    // Enables are gated by RESET_n so nothing is written while reset is low.
    assign PCWrite  = RESET_n & (nextpc | (pcs & condexreg));
    assign IRWrite  = RESET_n & irw;
    assign RegWrite = RESET_n & regw & condexreg & ~dp_nowrite;
    assign MemWrite = RESET_n & memw & condexreg;

    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign ImmSrc = Op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model
// queues per-cycle expected outputs, a monitor compares them on negedges.
module tb_multicycle_controller;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] RegSrc;
    logic [1:0] ImmSrc;
    logic [1:0] ALUControl;
    logic [3:0] Flags;

    multicycle_controller dut (
        .CLK(CLK),
        .RESET_n(RESET_n),
        .Cond(Cond),
        .Op(Op),
        .Funct(Funct),
        .Rd(Rd),
        .ALUFlags(ALUFlags),
        .PCWrite(PCWrite),
        .IRWrite(IRWrite),
        .RegWrite(RegWrite),
        .MemWrite(MemWrite),
        .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc),
        .RegSrc(RegSrc),
        .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
        .Flags(Flags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  mflags;
    logic [1:0]  cur_rs;
    logic [1:0]  cur_op;
    logic [19:0] obs;

    assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                  ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl, Flags};

    task automatic check(input string nm, input logic [19:0] got,
                         input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
        bit fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cd)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fn;
            4'd5:  return !fn;
            4'd6:  return fv;
            4'd7:  return !fv;
            4'd8:  return fc && !fz;
            4'd9:  return !fc || fz;
            4'd10: return fn == fv;
            4'd11: return fn != fv;
            4'd12: return !fz && (fn == fv);
            4'd13: return fz || (fn != fv);
            4'd14: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic push(input string nm, input bit pcw, irw, rw, mw, adr, sa,
                        input logic [1:0] sb, res, aluc, input logic [3:0] f);
        exp_t e;
        e.nm = nm;
        e.v = {pcw, irw, rw, mw, adr, sa, sb, res, cur_rs, cur_op, aluc, f};
        q.push_back(e);
    endtask

    task automatic model_push(input logic [3:0] cd, input logic [1:0] op,
                              input logic [5:0] fn, input logic [3:0] rd,
                              input logic [3:0] af, output int len);
        bit ce, pcrd, nw, s;
        logic [1:0] aluc;
        logic [3:0] f0;
        ce = cond_ok(cd, mflags);
        pcrd = ce && (rd == 4'hF);
        cur_rs = {op == 2'b01, op == 2'b10};
        cur_op = op;
        f0 = mflags;
        push("fetch", 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, f0);
        push("decode", 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, f0);
        len = 2;
        case (op)
            2'b01: begin
                push("memadr", 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, f0);
                if (fn[0]) begin
                    push("memrd", 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, f0);
                    push("memwb", pcrd, 0, ce, 0, 0, 0, 2'b00, 2'b01, 2'b00, f0);
                    len = 5;
                end else begin
                    push("memwr", 0, 0, 0, ce, 1, 0, 2'b00, 2'b00, 2'b00, f0);
                    len = 4;
                end
            end
            2'b00: begin
                s = fn[0];
                nw = 0;
                case (fn[4:1])
                    4'b0100: aluc = 2'b00;
                    4'b0010: aluc = 2'b01;
                    4'b0000: aluc = 2'b10;
                    4'b1100: aluc = 2'b11;
                    4'b1010: begin aluc = 2'b01; s = 1; nw = 1; end
                    default: begin aluc = 2'b00; nw = 1; end
                endcase
                push(fn[5] ? "execi" : "execr", 0, 0, 0, 0, 0, 0,
                     fn[5] ? 2'b01 : 2'b00, 2'b00, aluc, f0);
                if (ce && s) begin
                    mflags[3:2] = af[3:2];
                    if (aluc == 2'b00 || aluc == 2'b01) mflags[1:0] = af[1:0];
                end
                push("aluwb", pcrd, 0, ce && !nw, 0, 0, 0, 2'b00, 2'b00,
                     2'b00, mflags);
                len = 4;
            end
            2'b10: begin
                push("branch", ce, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, f0);
                len = 3;
            end
            default: len = 2;
        endcase
    endtask

    task automatic drive(input logic [3:0] cd, input logic [1:0] op,
                         input logic [5:0] fn, input logic [3:0] rd,
                         input logic [3:0] af);
        Cond = cd;
        Op = op;
        Funct = fn;
        Rd = rd;
        ALUFlags = af;
    endtask

    // Called one step after the edge that enters FETCH.
    task automatic issue(input logic [3:0] cd, input logic [1:0] op,
                         input logic [5:0] fn, input logic [3:0] rd,
                         input logic [3:0] af);
        int len;
        drive(cd, op, fn, rd, af);
        model_push(cd, op, fn, rd, af, len);
        repeat (len) @(posedge CLK);
        #1;
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.nm, obs, e.v);
            end
        end
    end

    initial begin
        int len;
        RESET_n = 1'b0;
        mflags = 4'h0;
        drive(4'hE, 2'b00, 6'b0, 4'h0, 4'h0);
        #3;
        check("reset_outputs", obs, 20'b0_0_0_0_0_1_10_10_00_00_00_0000);
        repeat (2) @(posedge CLK);
        #1 RESET_n = 1'b1;

        issue(4'hE, 2'b00, 6'b001001, 4'h1, 4'b0100);
        issue(4'hE, 2'b00, 6'b010101, 4'h2, 4'b0110);
        issue(4'h0, 2'b00, 6'b001000, 4'h3, 4'b0000);
        issue(4'h1, 2'b00, 6'b001000, 4'h3, 4'b0000);
        issue(4'hE, 2'b01, 6'b011001, 4'h4, 4'b0000);
        issue(4'hE, 2'b01, 6'b011000, 4'h4, 4'b0000);
        issue(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0000);
        issue(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
        issue(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0100);
        issue(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000);
        issue(4'hE, 2'b11, 6'b001001, 4'h6, 4'b1111);
        issue(4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000);
        issue(4'hE, 2'b00, 6'b001001, 4'h7, 4'b1111);

        drive(4'hE, 2'b01, 6'b011000, 4'h8, 4'b0000);
        model_push(4'hE, 2'b01, 6'b011000, 4'h8, 4'b0000, len);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1 check("memwr_before_reset", 20'(MemWrite), 20'd1);
        #1 RESET_n = 1'b0;
        #1;
        check("reset_memwrite", 20'(MemWrite), 20'd0);
        check("reset_flags", 20'(Flags), 20'h0);
        check("reset_irwrite", 20'(IRWrite), 20'd0);
        mflags = 4'h0;
        repeat (3) @(posedge CLK);
        #1 RESET_n = 1'b1;
        #1 check("release_irwrite", 20'(IRWrite), 20'd1);
        issue(4'hE, 2'b00, 6'b000100, 4'h9, 4'b1010);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] cd;
            logic [3:0] rd;
            cd = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            issue(cd, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), rd,
                  4'($urandom_range(0, 15)));
        end

        @(negedge CLK);
        #1 check("queue_drained", 20'(q.size()), 20'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit of the multicycle ARM datapath. A Moore state machine sequences each instruction through fetch, decode and execute steps, and decodes the ALU operation. It holds the NZCV flag register, evaluates condition codes and gates every architectural write. It drives ImmSrc, which is the Mode input of the downstream immediate extender, plus all datapath mux selects and write enables.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge
- RESET_n  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  gated write enables
- AdrSrc  out  1  0=PC, 1=Result as memory address
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01); combinational
- ImmSrc  out  2  equals Op; combinational
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- Flags  out  4  stored NZCV

## Operation
- States and transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 and Funct[5]=0 -> EXECR.
    - Op=00 and Funct[5]=1 -> EXECI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH, with no writes.
  - MEMADR: L=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR, EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Outputs per state; unlisted outputs are 0, and ALUOp=0 unless listed:
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUOp=1, ALUSrcB=00.
  - EXECI: ALUOp=1, ALUSrcB=01.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 gives ADD.
  - With ALUOp=1, cmd selects the operation:
    - 0100 ADD.
    - 0010 SUB.
    - 0000 AND.
    - 1100 ORR.
    - 1010 CMP: SUB with S forced to 1 and NoWrite=1.
    - Any other cmd: ADD with NoWrite=1.
  - FlagW[1] (NZ) = S.
  - FlagW[0] (CV) = S & (ADD|SUB).
  - FlagW = 0 when ALUOp=0.
- Condition code evaluation, against stored Flags:
  - EQ Z, NE !Z.
  - CS C, CC !C.
  - MI N, PL !N.
  - VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V.
  - GT !Z&(N==V), LE Z|(N!=V).
  - AL 1, and 1111 evaluates to 0.
- CondExReg:
  - Loaded with CondEx at the DECODE->next edge.
  - Held for the rest of the instruction.
  - Cleared in FETCH.
- PCS = Branch | (RegW & Rd==15).
- Write enables:
  - PCWrite = NextPC | (PCS & CondExReg).
  - RegWrite = RegW & CondExReg & !NoWrite.
  - MemWrite = MemW & CondExReg.
- Flag register:
  - Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondExReg.
  - Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondExReg.
  - Loads occur only in EXECR/EXECI.

## Timing
- Reset, asynchronous while RESET_n=0:
  - state=FETCH, Flags=0000, CondExReg=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced 0, combinationally gated.
  - All other outputs take their FETCH values.
- First rising edge after release performs the fetch.
- Reset asserted mid-instruction aborts immediately. No partial write occurs after RESET_n falls.
- Latency in cycles:
  - LDR 5.
  - STR 4.
  - Data-processing 4.
  - Branch 3.
  - Undefined (Op=11) 2.
- Flags updated at the end of EXECx are visible to the next instruction's condition check, never the current one.
- A failed condition still walks the full state sequence, with enables suppressed except the FETCH NextPC.

## Test plan
- Reset held 3 cycles mid-MEMWR (MemWrite=1), then released -> MemWrite drops with RESET_n, Flags=0000, next cycle IRWrite=1.
- ADDS Cond=1110, Op=00, Funct=001001, ALUFlags=0100 -> states FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in ALUWB; Flags=0100 after EXECI.
- CMP Funct=010101 with ALUFlags=0110, then ADD EQ -> no RegWrite for CMP; Flags=0110; following ADDEQ RegWrite=1; ADDNE RegWrite=0.
- LDR Op=01, L=1 -> 5 cycles, ImmSrc=01, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB; STR -> MemWrite=1 only in MEMWR.
- B Cond=0000 with Z=0 -> BRANCH reached, PCWrite=0 there; with Z=1 -> PCWrite=1, ImmSrc=10, RegSrc[0]=1.
- Op=11 -> DECODE returns to FETCH; RegWrite, MemWrite and Flags are unchanged; data-processing with Rd=15 and AL -> PCWrite=1 in ALUWB.
